// File: rtl/branch_target_pipe_if.sv
// Request/result bundle between a branch-issuing stage and branch_target_pipe.
// The master drives requests and the slave returns resolved targets plus the flush strobe.
interface branch_target_pipe_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pc_plus4;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             out_valid;
    logic [WIDTH-1:0] target;
    logic             taken;
    logic             wrap;
    logic             flush;

    modport master (
        output in_valid, mode, pc_plus4, imm, rs_data, rt_data,
        input  in_ready, out_valid, target, taken, wrap, flush
    );

    modport slave (
        input  in_valid, mode, pc_plus4, imm, rs_data, rt_data,
        output in_ready, out_valid, target, taken, wrap, flush
    );
endinterface

// File: rtl/branch_target_pipe.sv
// Resolves branch target/direction one cycle after accept.
// A taken result holds off new requests while flush is asserted.
//   state   | meaning
//   S_IDLE  | accepting requests
//   S_FLUSH | flush asserted, requests held off, r_cnt counts down to 0
module branch_target_pipe #(
    parameter int WIDTH        = 32,
    parameter int IMM_W        = 16,
    parameter int SHIFT        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_target_pipe_if.slave bus
);
    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    // Wide enough that the exact signed sum never overflows, so wrap is read off the upper bits.
    localparam int EXT_W = ((WIDTH > IMM_W + SHIFT) ? WIDTH : IMM_W + SHIFT) + 2;
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_cnt;
    logic [EXT_W-1:0] w_imm_ext;
    logic [EXT_W-1:0] w_off;
    logic [EXT_W-1:0] w_sum;
    logic             w_wrap;
    logic             w_taken;
    logic             w_accept;

    assign w_imm_ext = {{(EXT_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign w_off     = w_imm_ext << SHIFT;
    assign w_sum     = {{(EXT_W-WIDTH){1'b0}}, bus.pc_plus4} + w_off;
    assign w_wrap    = |w_sum[EXT_W-1:WIDTH];

    always_comb begin
        w_taken = 1'b0;
        case (bus.mode)
            2'b01:   w_taken = (bus.rs_data == bus.rt_data);
            2'b10:   w_taken = (bus.rs_data != bus.rt_data);
            2'b11:   w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign bus.in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign bus.flush    = (r_state == S_FLUSH);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_taken) w_next_state = S_FLUSH;
            S_FLUSH: if (r_cnt == 4'd0)       w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Terminal count at zero; the counter parks there instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_IDLE && w_next_state == S_FLUSH) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_FLUSH && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.target    <= '0;
            bus.taken     <= 1'b0;
            bus.wrap      <= 1'b0;
        end else begin
            bus.out_valid <= w_accept;
            if (w_accept) begin
                bus.target <= w_sum[WIDTH-1:0];
                bus.taken  <= w_taken;
                bus.wrap   <= w_wrap;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_pipe.sv
// Self-checking bench for branch_target_pipe: a reference model feeds a scoreboard
// that a negedge monitor drains, while scenario tasks check directed values inline.
module tb_branch_target_pipe;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        logic [31:0] target;
        logic        taken;
        logic        wrap;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_pipe_if #(.WIDTH(32), .IMM_W(16)) bus ();

    branch_target_pipe #(
        .WIDTH(32), .IMM_W(16), .SHIFT(2), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];
    res_t m_last  = '{target: 32'd0, taken: 1'b0, wrap: 1'b0};
    int   m_left  = 0;

    function automatic res_t model(input logic [1:0] mode, input logic [31:0] pc,
                                   input logic [15:0] imm, input logic [31:0] rs,
                                   input logic [31:0] rt);
        longint ex;
        res_t   r;
        ex       = longint'(pc) + longint'($signed(imm)) * 64'sd4;
        r.target = ex[31:0];
        r.wrap   = (ex < 0) || (ex > 64'sh0_FFFF_FFFF);
        case (mode)
            2'b01:   r.taken = (rs == rt);
            2'b10:   r.taken = (rs != rt);
            2'b11:   r.taken = 1'b1;
            default: r.taken = 1'b0;
        endcase
        return r;
    endfunction

    // Reference model: tracks its own flush window and pushes results on accepts.
    always @(posedge clk) begin
        res_t e;
        if (rst) begin
            sb.delete();
            m_left = 0;
            m_last = '{target: 32'd0, taken: 1'b0, wrap: 1'b0};
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (bus.in_valid) begin
            e = model(bus.mode, bus.pc_plus4, bus.imm, bus.rs_data, bus.rt_data);
            sb.push_back(e);
            m_last = e;
            if (e.taken) m_left = FLUSH_CYCLES;
        end
    end

    always @(negedge clk) begin
        res_t e;
        logic exp_valid;
        exp_valid = (sb.size() > 0);
        n_tests++;
        if (bus.out_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL mon_out_valid: got %b want %b at %0t", bus.out_valid, exp_valid, $time);
        end
        if (exp_valid) e = sb.pop_front();
        else           e = m_last;
        n_tests++;
        if (bus.target !== e.target || bus.taken !== e.taken || bus.wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL mon_result: got tgt=%h tk=%b wr=%b want tgt=%h tk=%b wr=%b at %0t",
                     bus.target, bus.taken, bus.wrap, e.target, e.taken, e.wrap, $time);
        end
        n_tests++;
        if (bus.flush !== (m_left > 0)) begin
            n_fail++;
            $display("FAIL mon_flush: got %b want %b at %0t", bus.flush, (m_left > 0), $time);
        end
        n_tests++;
        if (bus.in_ready !== (m_left == 0 && !rst)) begin
            n_fail++;
            $display("FAIL mon_in_ready: got %b want %b at %0t", bus.in_ready, (m_left == 0 && !rst), $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] mode, input logic [31:0] pc,
                           input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = v;
        bus.mode     = mode;
        bus.pc_plus4 = pc;
        bus.imm      = imm;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b1, 2'b11, 32'h40, 16'h4, 32'd0, 32'd0);
        repeat (3) step();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.target !== 32'd0 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b rdy=%b tgt=%h fl=%b want 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.target, bus.flush);
        end
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_beq_taken();
        step();
        set_req(1'b1, 2'b01, 32'd4, 16'd2, 32'd7, 32'd7);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'd12 || bus.taken !== 1'b1 ||
            bus.wrap !== 1'b0 || bus.flush !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_result: got ov=%b tgt=%h tk=%b wr=%b fl=%b rdy=%b want 1 0000000c 1 0 1 0",
                     bus.out_valid, bus.target, bus.taken, bus.wrap, bus.flush, bus.in_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.flush !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_flush2: got fl=%b rdy=%b ov=%b want 1 0 0", bus.flush, bus.in_ready, bus.out_valid);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.flush !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_flush_end: got fl=%b rdy=%b want 0 1", bus.flush, bus.in_ready);
        end
    endtask

    task automatic test_bne_back_to_back();
        step();
        set_req(1'b1, 2'b10, 32'd18, 16'd1, 32'd5, 32'd5);
        step();
        set_req(1'b1, 2'b11, 32'd100, 16'd3, 32'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'd22 || bus.taken !== 1'b0 ||
            bus.flush !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_result: got ov=%b tgt=%h tk=%b fl=%b rdy=%b want 1 00000016 0 0 1",
                     bus.out_valid, bus.target, bus.taken, bus.flush, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'd112 || bus.taken !== 1'b1 || bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got ov=%b tgt=%h tk=%b fl=%b want 1 00000070 1 1",
                     bus.out_valid, bus.target, bus.taken, bus.flush);
        end
        step();
        step();
        @(negedge clk);
        n_tests++;
        if (bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_flush_end: got %b want 0", bus.flush);
        end
    endtask

    task automatic test_wrap();
        step();
        set_req(1'b1, 2'b00, 32'h10, 16'hFFFF, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.target !== 32'h0000000C || bus.taken !== 1'b0 || bus.wrap !== 1'b0 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_imm: got tgt=%h tk=%b wr=%b fl=%b want 0000000c 0 0 0",
                     bus.target, bus.taken, bus.wrap, bus.flush);
        end
        step();
        set_req(1'b1, 2'b11, 32'hFFFFFFFC, 16'd1, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.target !== 32'h0 || bus.taken !== 1'b1 || bus.wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: got tgt=%h tk=%b wr=%b want 00000000 1 1", bus.target, bus.taken, bus.wrap);
        end
        step();
        step();
        set_req(1'b1, 2'b00, 32'h4, 16'hFFFE, 32'd0, 32'd0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'hFFFFFFFC || bus.wrap !== 1'b1 || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_down: got ov=%b tgt=%h wr=%b tk=%b want 1 fffffffc 1 0",
                     bus.out_valid, bus.target, bus.wrap, bus.taken);
        end
    endtask

    task automatic test_hold_through_flush();
        step();
        set_req(1'b1, 2'b01, 32'h100, 16'd8, 32'd3, 32'd3);
        step();
        set_req(1'b1, 2'b01, 32'h200, 16'hFFFF, 32'd1, 32'd2);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'h120 || bus.flush !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_first: got ov=%b tgt=%h fl=%b rdy=%b want 1 00000120 1 0",
                     bus.out_valid, bus.target, bus.flush, bus.in_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_in_flush: got ov=%b fl=%b want 0 1", bus.out_valid, bus.flush);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.flush !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reopen: got ov=%b fl=%b rdy=%b want 0 0 1", bus.out_valid, bus.flush, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'h1FC || bus.taken !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_accept: got ov=%b tgt=%h tk=%b want 1 000001fc 0", bus.out_valid, bus.target, bus.taken);
        end
    endtask

    task automatic test_reset_in_flush();
        step();
        set_req(1'b1, 2'b11, 32'h40, 16'd4, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        set_req(1'b1, 2'b11, 32'h80, 16'd4, 32'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.target !== 32'h50 || bus.flush !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfl_before: got ov=%b tgt=%h fl=%b rdy=%b want 1 00000050 1 0",
                     bus.out_valid, bus.target, bus.flush, bus.in_ready);
        end
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.flush !== 1'b0 || bus.out_valid !== 1'b0 || bus.target !== 32'd0 ||
            bus.taken !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstfl_after: got fl=%b ov=%b tgt=%h tk=%b rdy=%b want 0 0 0 0 1",
                     bus.flush, bus.out_valid, bus.target, bus.taken, bus.in_ready);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstfl_idle: got ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs;
        for (int i = 0; i < 120; i++) begin
            step();
            rs  = $urandom;
            rst = ($urandom_range(0, 24) == 0);
            set_req(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                    16'($urandom), rs, ($urandom_range(0, 1) == 1) ? rs : $urandom);
        end
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (FLUSH_CYCLES + 2) step();
        @(negedge clk);
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        set_req(1'b0, 2'b00, 32'd0, 16'd0, 32'd0, 32'd0);
        test_reset();
        test_beq_taken();
        test_bne_back_to_back();
        test_wrap();
        test_hold_through_flush();
        test_reset_in_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
